// File: rtl/bank_write_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_write_sched                                                       |
// | Three-requester (i/d/c) write scheduler with one-entry holding slots,  |
// | fixed priority plus starvation promotion, feeding one registered port. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bank_write_sched #(
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 64,
  parameter int STARVE   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         i_valid,
  input  logic [BANKBITS+WORDBITS-1:0] i_addr,
  input  logic [DATABITS-1:0]          i_data,
  output logic                         i_ready,

  input  logic                         d_valid,
  input  logic [BANKBITS+WORDBITS-1:0] d_addr,
  input  logic [DATABITS-1:0]          d_data,
  output logic                         d_ready,

  input  logic                         c_valid,
  input  logic [BANKBITS+WORDBITS-1:0] c_addr,
  input  logic [DATABITS-1:0]          c_data,
  output logic                         c_ready,

  input  logic                         o_stall,
  output logic                         o_en,
  output logic [BANKBITS+WORDBITS-1:0] o_addr,
  output logic [DATABITS-1:0]          o_data,
  output logic [1:0]                   muxcode
);

  localparam int ADDRBITS = BANKBITS + WORDBITS;

  localparam logic [3:0] c_starve   = 4'(STARVE);
  localparam logic [1:0] c_src_i    = 2'd0;
  localparam logic [1:0] c_src_d    = 2'd1;
  localparam logic [1:0] c_src_c    = 2'd2;
  localparam logic [1:0] c_src_idle = 2'd3;

  // Requester index 0=i, 1=d, 2=c matches the muxcode encoding.
  logic [2:0]          w_valid;
  logic [ADDRBITS-1:0] w_addr [3];
  logic [DATABITS-1:0] w_data [3];

  logic [2:0]          r_pending;
  logic [ADDRBITS-1:0] r_hold_addr [3];
  logic [DATABITS-1:0] r_hold_data [3];
  logic [3:0]          r_age_d;
  logic [3:0]          r_age_c;

  logic [2:0]          w_grant;
  logic [1:0]          w_win_code;
  logic [ADDRBITS-1:0] w_win_addr;
  logic [DATABITS-1:0] w_win_data;

  assign w_valid   = {c_valid, d_valid, i_valid};
  assign w_addr[0] = i_addr;
  assign w_addr[1] = d_addr;
  assign w_addr[2] = c_addr;
  assign w_data[0] = i_data;
  assign w_data[1] = d_data;
  assign w_data[2] = c_data;

  assign i_ready = ~r_pending[0];
  assign d_ready = ~r_pending[1];
  assign c_ready = ~r_pending[2];

  function automatic logic [3:0] age_inc(input logic [3:0] age);
    return (age >= c_starve) ? c_starve : age + 4'd1;
  endfunction

  // Aged requesters outrank the fixed i > d > c order; no grant while stalled.
  always_comb begin
    w_grant    = 3'b000;
    w_win_code = c_src_idle;
    if (!o_stall) begin
      if (r_pending[2] && (r_age_c == c_starve)) begin
        w_grant    = 3'b100;
        w_win_code = c_src_c;
      end else if (r_pending[1] && (r_age_d == c_starve)) begin
        w_grant    = 3'b010;
        w_win_code = c_src_d;
      end else if (r_pending[0]) begin
        w_grant    = 3'b001;
        w_win_code = c_src_i;
      end else if (r_pending[1]) begin
        w_grant    = 3'b010;
        w_win_code = c_src_d;
      end else if (r_pending[2]) begin
        w_grant    = 3'b100;
        w_win_code = c_src_c;
      end
    end
  end

  always_comb begin
    w_win_addr = r_hold_addr[0];
    w_win_data = r_hold_data[0];
    if (w_grant[1]) begin
      w_win_addr = r_hold_addr[1];
      w_win_data = r_hold_data[1];
    end else if (w_grant[2]) begin
      w_win_addr = r_hold_addr[2];
      w_win_data = r_hold_data[2];
    end
  end

  // A slot is either free (may capture) or pending (may be granted), never both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 3'b000;
      for (int p = 0; p < 3; p++) begin
        r_hold_addr[p] <= '0;
        r_hold_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (w_valid[p] && !r_pending[p]) begin
          r_pending[p]   <= 1'b1;
          r_hold_addr[p] <= w_addr[p];
          r_hold_data[p] <= w_data[p];
        end else if (w_grant[p]) begin
          r_pending[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age_d <= 4'd0;
      r_age_c <= 4'd0;
    end else if (!o_stall) begin
      r_age_d <= (r_pending[1] && !w_grant[1]) ? age_inc(r_age_d) : 4'd0;
      r_age_c <= (r_pending[2] && !w_grant[2]) ? age_inc(r_age_c) : 4'd0;
    end
  end

  // Address/data keep their last value when idle so the port sees no toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_en    <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      muxcode <= c_src_idle;
    end else if (!o_stall) begin
      if (|w_grant) begin
        o_en    <= 1'b1;
        o_addr  <= w_win_addr;
        o_data  <= w_win_data;
        muxcode <= w_win_code;
      end else begin
        o_en    <= 1'b0;
        muxcode <= c_src_idle;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_write_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bank_write_sched                                                    |
// | Directed and random stimulus with a queue-based write scoreboard.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_bank_write_sched;

  localparam int AW     = 14;
  localparam int DW     = 64;
  localparam int STARVE = 4;

  typedef struct packed {
    logic [1:0]    code;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid [3];
  logic [AW-1:0] req_addr  [3];
  logic [DW-1:0] req_data  [3];
  logic [2:0]    rdy;
  logic          o_stall = 1'b0;
  logic          o_en;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [1:0]    muxcode;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bank_write_sched #(
    .BANKBITS(5), .WORDBITS(9), .DATABITS(DW), .STARVE(STARVE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(req_valid[0]), .i_addr(req_addr[0]), .i_data(req_data[0]), .i_ready(rdy[0]),
    .d_valid(req_valid[1]), .d_addr(req_addr[1]), .d_data(req_data[1]), .d_ready(rdy[1]),
    .c_valid(req_valid[2]), .c_addr(req_addr[2]), .c_data(req_data[2]), .c_ready(rdy[2]),
    .o_stall(o_stall), .o_en(o_en), .o_addr(o_addr), .o_data(o_data), .muxcode(muxcode)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: slots, waiting time in unstalled edges, expected port state.
  bit            m_pend [3];
  logic [AW-1:0] m_saddr [3];
  logic [DW-1:0] m_sdata [3];
  int            m_wait [3];
  logic          m_en   = 1'b0;
  logic [1:0]    m_code = 2'd3;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  wr_t           exp_q [$];
  logic          last_stall = 1'b1;
  bit            pend_before [3];
  int            win;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        m_pend[p] = 0;
        m_wait[p] = 0;
      end
      m_en = 1'b0; m_code = 2'd3; m_addr = '0; m_data = '0;
      exp_q.delete();
      last_stall = 1'b1;
    end else begin
      pend_before = m_pend;
      last_stall  = o_stall;
      if (!o_stall) begin
        win = -1;
        if (m_pend[2] && m_wait[2] >= STARVE) win = 2;
        else if (m_pend[1] && m_wait[1] >= STARVE) win = 1;
        else for (int p = 0; p < 3; p++) if (win < 0 && m_pend[p]) win = p;
        for (int p = 0; p < 3; p++) m_wait[p] = (m_pend[p] && p != win) ? m_wait[p] + 1 : 0;
        if (win >= 0) begin
          m_en = 1'b1; m_code = win[1:0]; m_addr = m_saddr[win]; m_data = m_sdata[win];
          m_pend[win] = 0;
          exp_q.push_back({win[1:0], m_saddr[win], m_sdata[win]});
        end else begin
          m_en = 1'b0; m_code = 2'd3;
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (req_valid[p] && !pend_before[p]) begin
          m_pend[p] = 1; m_saddr[p] = req_addr[p]; m_sdata[p] = req_data[p]; m_wait[p] = 0;
        end
      end
    end
  end

  // Monitor: per-cycle state plus one scoreboard pop per freshly presented write.
  wr_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", rdy, {~m_pend[2], ~m_pend[1], ~m_pend[0]});
      chk("port_state", {o_en, muxcode, o_addr, o_data}, {m_en, m_code, m_addr, m_data});
      if (o_en && !last_stall) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL write_unexpected: got code %0h addr %0h, expected no write", muxcode, o_addr);
        end else begin
          e = exp_q.pop_front();
          chk("write", {muxcode, o_addr, o_data}, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    for (int p = 0; p < 3; p++) begin
      req_valid[p] = 1'b0;
      req_addr[p]  = '0;
      req_data[p]  = '0;
    end
    o_stall = 1'b0;
  endtask

  task automatic load_all();
    for (int p = 0; p < 3; p++) begin
      req_valid[p] = 1'b1;
      req_addr[p]  = AW'(p + 16);
      req_data[p]  = DW'(64'hA000 + p);
    end
  endtask

  logic [AW+2:0] held;
  int seen_at;

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {o_en, muxcode, o_addr, o_data}, {1'b0, 2'd3, {AW{1'b0}}, {DW{1'b0}}});
    chk("reset_ready", rdy, 3'b111);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write from d.
    req_valid[1] = 1'b1; req_addr[1] = 14'h0A5; req_data[1] = 64'h1234;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("single_captured", rdy, 3'b101);
    @(negedge clk);
    chk("single_grant", {o_en, muxcode, o_addr, o_data}, {1'b1, 2'd1, 14'h0A5, 64'h1234});
    @(negedge clk);
    chk("single_idle", {o_en, muxcode}, {1'b0, 2'd3});

    // Fixed priority i > d > c.
    load_all();
    @(negedge clk);
    idle_inputs();
    chk("prio_captured", rdy, 3'b000);
    @(negedge clk);
    chk("prio_i", {o_en, muxcode, rdy}, {1'b1, 2'd0, 3'b001});
    @(negedge clk);
    chk("prio_d", {o_en, muxcode, rdy}, {1'b1, 2'd1, 3'b011});
    @(negedge clk);
    chk("prio_c", {o_en, muxcode, rdy}, {1'b1, 2'd2, 3'b111});
    @(negedge clk);

    // d must get through while i keeps requesting.
    req_valid[0] = 1'b1; req_addr[0] = 14'h111; req_data[0] = 64'h1;
    req_valid[1] = 1'b1; req_addr[1] = 14'h222; req_data[1] = 64'h2;
    seen_at = 99;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid[1] = 1'b0;
      req_data[0]  = DW'(k + 2);
      if (o_en && muxcode == 2'd1 && seen_at == 99) seen_at = k;
    end
    chk("starve_d_by_edge5", seen_at <= 5, 1'b1);
    idle_inputs();
    repeat (3) @(negedge clk);

    // All three continuously requesting: c must be promoted by aging.
    load_all();
    seen_at = 99;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) req_data[p] = DW'($urandom);
      if (o_en && muxcode == 2'd2 && seen_at == 99) seen_at = k;
    end
    chk("starve_c_promoted", seen_at <= 6, 1'b1);
    idle_inputs();
    repeat (4) @(negedge clk);

    // Stall with a valid output.
    load_all();
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    held = {o_en, muxcode, o_addr};
    o_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold", {o_en, muxcode, o_addr}, held);
    end
    o_stall = 1'b0;
    @(negedge clk);
    chk("stall_resume_d", {o_en, muxcode}, {1'b1, 2'd1});
    @(negedge clk);
    chk("stall_resume_c", {o_en, muxcode}, {1'b1, 2'd2});
    @(negedge clk);

    // Asynchronous reset between edges with slots pending.
    load_all();
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out", {o_en, muxcode, o_addr, o_data}, {1'b0, 2'd3, {AW{1'b0}}, {DW{1'b0}}});
    chk("async_reset_ready", rdy, 3'b111);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_write", o_en, 1'b0);
    end

    // Random traffic with stalls.
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < 3; p++) begin
        req_valid[p] = ($urandom_range(3) != 0);
        req_addr[p]  = AW'($urandom);
        req_data[p]  = {$urandom, $urandom};
      end
      o_stall = (k < 1000) ? ($urandom_range(4) == 0) : ($urandom_range(9) == 0);
      @(negedge clk);
    end

    idle_inputs();
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
